seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
Multi-cycle, parametrised ripple adder. It adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, and carries between chunks in a register. This trades latency for a narrow carry chain. It is the sequential, width-generic successor to the team's 4-bit ripple adder, with a start/busy/done handshake and signed-overflow detection.

Parameters:
WIDTH, 16, operand and sum width in bits; must be an integer multiple of CHUNK
CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH
(derived, not overridable) NCHUNK = WIDTH/CHUNK, number of RUN cycles

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request to add; sampled only in IDLE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while an addition is in progress (RUN state)
done  output  1  single-cycle pulse: result valid
sum  output  WIDTH  registered result, held until the next completion
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  two's-complement signed overflow of the last result

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, sum, cout and ovf all 0; internal operand, carry, index and accumulator registers cleared. Reset mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE: on a clock edge with start=1, capture a, b and cin into internal registers, set carry=cin and idx=0, clear the accumulator, go to RUN. With start=0, remain in IDLE.
- RUN (busy=1):
  - Each cycle: {c, s} = A[idx*CHUNK +: CHUNK] + B[idx*CHUNK +: CHUNK] + carry, using a CHUNK+1-bit sum.
  - acc[idx*CHUNK +: CHUNK] <= s; carry <= c; idx <= idx+1.
  - After processing idx = NCHUNK-1, go to DONE. On that same edge, update sum (<= final acc including the last chunk), cout (<= c) and ovf (<= (A[W-1]==B[W-1]) && (final sum[W-1] != A[W-1])).
- DONE: done=1 and busy=0 for exactly one cycle, then unconditionally return to IDLE. start is ignored in DONE.
- Latency: start accepted at edge E0; busy high for cycles E0..E0+NCHUNK-1; done high in the cycle following edge E0+NCHUNK. A new start is accepted at the earliest at edge E0+NCHUNK+2.
- sum, cout and ovf change only on the completion edge. They never show partial results and hold their value through IDLE and the next RUN.
- start asserted during RUN or DONE is ignored, not queued. Changes to a, b or cin after capture have no effect on the operation in progress.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true carry out; ovf is the signed interpretation only.
- CHUNK==WIDTH: a single RUN cycle; done arrives 2 edges after start.
- idx width is clog2(NCHUNK), minimum 1 bit. NCHUNK need not be a power of 2.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> busy=0, done=0, sum=0x0000, cout=0, ovf=0 immediately, without waiting for a clock edge.
- WIDTH=16/CHUNK=4: a=0x0001, b=0x0000, cin=0, start pulse -> busy high 4 cycles; done pulses 1 cycle later; sum=0x0001, cout=0, ovf=0.
- Full carry propagation: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Ignored inputs: a=0x1234, b=0x4321, cin=1, start. During RUN, drive a=0xFFFF and b=0xFFFF with start held high -> result sum=0x5556, cout=0. Exactly one done pulse; no second operation begins until start is seen in IDLE.
- Reset mid-run: start with a=0x00FF, b=0x0001; assert rst during the 2nd RUN cycle -> no done pulse, outputs 0. A subsequent start with a=0x0002, b=0x0003 gives sum=0x0005.
- Degenerate instance WIDTH=4/CHUNK=4: a=0xD, b=0xA, cin=1 -> done 2 edges after start, sum=0x8, cout=1, ovf=0.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Sequential ripple adder: adds a + b + cin CHUNK bits per clock, carrying between chunks in a register.
// Latency NCHUNK+1 edges from accepted start to done; start is only honoured in IDLE, never queued.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] acc;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_upd;
  logic             last;
  logic             ovf_next;

  assign last = (idx == LAST_IDX);

  // Chunk select and write-back are explicit muxes so idx never needs to be
  // widened into a bit offset.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == IW'(k)) begin
        a_chunk = op_a[k*CHUNK +: CHUNK];
        b_chunk = op_b[k*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    acc_upd = acc;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == IW'(k)) begin
        acc_upd[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      end
    end
    ovf_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (acc_upd[WIDTH-1] != op_a[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Result registers load only on the completion edge, so partial sums never escape.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_upd;
          carry <= chunk_sum[CHUNK];
          idx   <= last ? '0 : idx + IW'(1);
          if (last) begin
            sum  <= acc_upd;
            cout <= chunk_sum[CHUNK];
            ovf  <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: 16/4 instance with vector table and random ops, plus a 4/4 degenerate instance.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        cin4 = 1'b0;
  logic        busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  typedef struct {
    string       name;
    logic [15:0] va;
    logic [15:0] vb;
    logic        vc;
    bit          hold;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; overflow means the true signed sum leaves the 16-bit range.
  function automatic logic [17:0] ref_add16(input logic [15:0] x, input logic [15:0] y, input logic c);
    int sx, sy, r;
    logic [16:0] u;
    sx = x[15] ? int'(x) - 65536 : int'(x);
    sy = y[15] ? int'(y) - 65536 : int'(y);
    r  = sx + sy + int'(c);
    u  = 17'(x) + 17'(y) + 17'(c);
    return {(r > 32767 || r < -32768), u};
  endfunction

  function automatic logic [5:0] ref_add4(input logic [3:0] x, input logic [3:0] y, input logic c);
    int sx, sy, r;
    logic [4:0] u;
    sx = x[3] ? int'(x) - 16 : int'(x);
    sy = y[3] ? int'(y) - 16 : int'(y);
    r  = sx + sy + int'(c);
    u  = 5'(x) + 5'(y) + 5'(c);
    return {(r > 7 || r < -8), u};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
  task automatic do_op(input string nm, input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input bit hold, input logic [15:0] es, input logic ec, input logic eo);
    int k;
    int busy_cnt;
    bit held;
    logic [15:0] prev_sum;
    prev_sum = sum;
    held = 1'b1;
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    if (hold) begin
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
    end else begin
      start = 1'b0;
    end
    busy_cnt = 0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (sum !== prev_sum) held = 1'b0;
      k++;
      @(negedge clk);
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_busy_cycles"}, busy_cnt, 4);
    chk({nm, "_held"}, 32'(held), 32'd1);
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
    start = 1'b0;
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'({done, busy}), 32'd0);
    if (hold) begin
      @(negedge clk);
      chk({nm, "_no_requeue"}, 32'({done, busy}), 32'd0);
    end
  endtask

  initial begin
    vec_t vecs[7];
    logic [17:0] r16;
    logic [5:0]  r4;
    logic [15:0] ra, rb;
    logic        rc;
    logic [3:0]  qa, qb;
    logic        qc;
    int          k;
    bit          saw_done;

    vecs[0] = '{"one",      16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[1] = '{"fullcarry",16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"posovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"ignored",  16'h1234, 16'h4321, 1'b1, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[4] = '{"negovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{"allones",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{"checker",  16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    #1;
    chk("reset_outputs", 32'({busy, done, sum, cout, ovf}), 32'd0);
    chk("reset_outputs4", 32'({busy4, done4, sum4, cout4, ovf4}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].hold,
            vecs[i].es, vecs[i].ec, vecs[i].eo);
    end

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i % 8 == 0) ra = 16'h7FFF;
      if (i % 8 == 1) rb = 16'h8000;
      r16 = ref_add16(ra, rb, rc);
      do_op("rand", ra, rb, rc, bit'(i % 5 == 0), r16[15:0], r16[16], r16[17]);
    end

    // Asynchronous reset during the second RUN cycle, with a nonzero prior result visible.
    do_op("pre_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrun_rst_outputs", 32'({busy, done, sum, cout, ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("midrun_rst_no_done", 32'(saw_done), 32'd0);
    chk("midrun_rst_sum", 32'(sum), 32'd0);
    do_op("after_rst", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);

    // Single-chunk instance: done two edges after start.
    a4 = 4'hD; b4 = 4'hA; cin4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("deg_busy", 32'({busy4, done4}), 32'b10);
    @(negedge clk);
    chk("deg_done", 32'({busy4, done4}), 32'b01);
    chk("deg_result", 32'({sum4, cout4, ovf4}), 32'({4'h8, 1'b1, 1'b0}));
    @(negedge clk);
    chk("deg_done_pulse", 32'(done4), 32'd0);

    for (int i = 0; i < 12; i++) begin
      qa = 4'($urandom);
      qb = 4'($urandom);
      qc = 1'($urandom);
      r4 = ref_add4(qa, qb, qc);
      a4 = qa; b4 = qb; cin4 = qc; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      k = 0;
      while (done4 !== 1'b1 && k < 10) begin
        k++;
        @(negedge clk);
      end
      chk("deg_rand_latency", k, 1);
      chk("deg_rand_result", 32'({sum4, cout4, ovf4}), 32'({r4[3:0], r4[4], r4[5]}));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
